phase_search_ctrl: RTL and testbench

Consumer of the sync detector's search kicks (next-phase / depuncturer next-state), sitting between the demodulator soft-symbol input and the LLR former/depuncturer.
- Holds the current phase hypothesis (constellation rotation) and puncture offset hypothesis.
- Rotates incoming soft I/Q symbols accordingly.
- Returns the last-phase strobe the sync detector needs to decide between a phase kick and a depuncturer kick.

---
 rtl/phase_search_if.sv | 31 +++
 rtl/phase_search_ctrl.sv | 153 +++++++++++++++
 tb/tb_phase_search_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_search_if.sv
// Soft-symbol stream and search-control bundle between sync detector, demod and LLR former.
interface phase_search_if #(
  parameter int LLR_WIDTH   = 4,
  parameter int SWEEP_WIDTH = 8
);
  logic [1:0]                  i_code_rate;
  logic                        i_next_phase;
  logic                        i_deperf_next_st;
  logic                        i_is_sync;
  logic                        i_vld;
  logic signed [LLR_WIDTH-1:0] i_i;
  logic signed [LLR_WIDTH-1:0] i_q;
  logic                        o_vld;
  logic signed [LLR_WIDTH-1:0] o_i;
  logic signed [LLR_WIDTH-1:0] o_q;
  logic [2:0]                  o_phase;
  logic [2:0]                  o_punct_offset;
  logic                        o_last_phase_stb;
  logic [SWEEP_WIDTH-1:0]      o_sweep_cnt;
  logic                        o_proto_err;

  modport master (
    output i_code_rate, i_next_phase, i_deperf_next_st, i_is_sync, i_vld, i_i, i_q,
    input  o_vld, o_i, o_q, o_phase, o_punct_offset, o_last_phase_stb, o_sweep_cnt, o_proto_err
  );

  modport slave (
    input  i_code_rate, i_next_phase, i_deperf_next_st, i_is_sync, i_vld, i_i, i_q,
    output o_vld, o_i, o_q, o_phase, o_punct_offset, o_last_phase_stb, o_sweep_cnt, o_proto_err
  );
endinterface

// File: rtl/phase_search_ctrl.sv
// Phase / puncture-offset hypothesis controller with saturating soft I/Q rotation.
// Optional macro PHASE_SEARCH_SPECTRUM_INV_EN adds an I/Q-swapped hypothesis set.
module phase_search_ctrl #(
  parameter int LLR_WIDTH   = 4,
  parameter int NUM_ROT     = 4,
  parameter int SWEEP_WIDTH = 8
) (
  input logic           clk,
  input logic           reset_n,
  phase_search_if.slave bus
);
  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2,
    RATE_7_8 = 2'd3
  } rate_e;

`ifdef PHASE_SEARCH_SPECTRUM_INV_EN
  localparam int NUM_HYP = 2 * NUM_ROT;
`else
  localparam int NUM_HYP = NUM_ROT;
`endif
  localparam logic [2:0] LAST_PH = 3'(NUM_HYP - 1);
  localparam logic signed [LLR_WIDTH-1:0] LLR_MIN = {1'b1, {(LLR_WIDTH-1){1'b0}}};
  localparam logic signed [LLR_WIDTH-1:0] LLR_MAX = {1'b0, {(LLR_WIDTH-1){1'b1}}};

  rate_e                       rate_q, rate_d, rate_in;
  logic                        sync_q, sync_d;
  logic [2:0]                  phase_q, phase_d, offset_q, offset_d, period;
  logic [SWEEP_WIDTH-1:0]      sweep_q, sweep_d;
  logic                        stb_q, stb_d, err_q, err_d, vld_q, vld_d;
  logic signed [LLR_WIDTH-1:0] oi_q, oi_d, oq_q, oq_d;
  logic signed [LLR_WIDTH-1:0] src_i, src_q, rot_i, rot_q;
  logic [1:0]                  rot;

  function automatic logic signed [LLR_WIDTH-1:0] sat_neg(input logic signed [LLR_WIDTH-1:0] x);
    return (x == LLR_MIN) ? LLR_MAX : -x;
  endfunction

  assign rate_in = rate_e'(bus.i_code_rate);

  always_comb begin
    period = 3'd1;
    unique case (rate_q)
      RATE_1_2: period = 3'd1;
      RATE_2_3: period = 3'd2;
      RATE_3_4: period = 3'd3;
      RATE_7_8: period = 3'd7;
    endcase
  end

  // Rate change outranks everything else; sync freezes hypotheses but still clears the sweep count on its rising edge.
  always_comb begin
    rate_d   = rate_in;
    sync_d   = bus.i_is_sync;
    phase_d  = phase_q;
    offset_d = offset_q;
    sweep_d  = sweep_q;
    stb_d    = 1'b0;
    err_d    = err_q;
    if (rate_in != rate_q) begin
      phase_d  = '0;
      offset_d = '0;
      sweep_d  = '0;
    end else begin
      if (bus.i_is_sync && !sync_q) sweep_d = '0;
      if (!bus.i_is_sync) begin
        if (bus.i_deperf_next_st) begin
          phase_d = '0;
          if (offset_q + 3'd1 >= period) begin
            offset_d = '0;
            if (sweep_q != '1) sweep_d = sweep_q + SWEEP_WIDTH'(1);
          end else begin
            offset_d = offset_q + 3'd1;
          end
        end else if (bus.i_next_phase) begin
          if (phase_q == LAST_PH) begin
            err_d = 1'b1;
          end else begin
            phase_d = phase_q + 3'd1;
            stb_d   = (phase_q + 3'd1 == LAST_PH);
          end
        end
      end
    end
  end

  always_comb begin
    src_i = bus.i_i;
    src_q = bus.i_q;
    rot   = phase_q[1:0];
`ifdef PHASE_SEARCH_SPECTRUM_INV_EN
    if (phase_q >= 3'(NUM_ROT)) begin
      src_i = bus.i_q;
      src_q = bus.i_i;
      rot   = 2'(phase_q - 3'(NUM_ROT));
    end
`endif
    // Binary hypothesis space only distinguishes 0 and 180 degrees.
    if (NUM_ROT == 2) rot = {rot[0], 1'b0};
    rot_i = src_i;
    rot_q = src_q;
    unique case (rot)
      2'd0: begin rot_i = src_i;          rot_q = src_q;          end
      2'd1: begin rot_i = sat_neg(src_q); rot_q = src_i;          end
      2'd2: begin rot_i = sat_neg(src_i); rot_q = sat_neg(src_q); end
      2'd3: begin rot_i = src_q;          rot_q = sat_neg(src_i); end
    endcase
    vld_d = bus.i_vld;
    oi_d  = bus.i_vld ? rot_i : oi_q;
    oq_d  = bus.i_vld ? rot_q : oq_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate_q   <= RATE_1_2;
      sync_q   <= 1'b0;
      phase_q  <= '0;
      offset_q <= '0;
      sweep_q  <= '0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      oi_q     <= '0;
      oq_q     <= '0;
    end else begin
      rate_q   <= rate_d;
      sync_q   <= sync_d;
      phase_q  <= phase_d;
      offset_q <= offset_d;
      sweep_q  <= sweep_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      oi_q     <= oi_d;
      oq_q     <= oq_d;
    end
  end

`ifdef PHASE_SEARCH_SPECTRUM_INV_EN
  assign bus.o_phase = phase_q;
`else
  assign bus.o_phase = (NUM_ROT <= 4) ? {1'b0, phase_q[1:0]} : phase_q;
`endif
  assign bus.o_punct_offset   = offset_q;
  assign bus.o_last_phase_stb = stb_q;
  assign bus.o_sweep_cnt      = sweep_q;
  assign bus.o_proto_err      = err_q;
  assign bus.o_vld            = vld_q;
  assign bus.o_i              = oi_q;
  assign bus.o_q              = oq_q;
endmodule

// File: tb/tb_phase_search_ctrl.sv
// Scoreboard bench for phase_search_ctrl: arithmetic reference model, negedge monitor.
module tb_phase_search_ctrl;
  localparam int LW   = 4;
  localparam int NR   = 4;
  localparam int SW   = 8;
`ifdef PHASE_SEARCH_SPECTRUM_INV_EN
  localparam int NHYP = 2 * NR;
`else
  localparam int NHYP = NR;
`endif
  localparam int LAST = NHYP - 1;
  localparam int LMIN = -(1 << (LW - 1));
  localparam int LMAX = (1 << (LW - 1)) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  phase_search_if #(.LLR_WIDTH(LW), .SWEEP_WIDTH(SW)) bus ();

  phase_search_ctrl #(.LLR_WIDTH(LW), .NUM_ROT(NR), .SWEEP_WIDTH(SW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {int i; int q;} samp_t;
  samp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int m_phase, m_off, m_sweep, m_rate, m_last_i, m_last_q;
  bit m_err, m_stb, m_vld, m_sync;
  bit started = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > LMAX) ? LMAX : ((v < LMIN) ? LMIN : v);
  endfunction

  function automatic int period_of(input int r);
    case (r)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 7;
    endcase
  endfunction

  // Rotation as multiplication of (I + jQ) by j^k; swapped hypotheses start from (Q + jI).
  function automatic samp_t rotate(input int ph, input int i, input int q);
    samp_t r;
    int re, im, k, t;
    re = i; im = q; k = ph;
    if (ph >= NR) begin re = q; im = i; k = ph - NR; end
    if (NR == 2) k = 2 * k;
    for (int n = 0; n < k; n++) begin
      t = re; re = -im; im = t;
    end
    r.i = clamp(re);
    r.q = clamp(im);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase = 0; m_off = 0; m_sweep = 0; m_rate = 0; m_sync = 0;
      m_err = 0; m_stb = 0; m_vld = 0; m_last_i = 0; m_last_q = 0;
      sb.delete();
    end else begin
      m_vld = bus.i_vld;
      if (bus.i_vld) sb.push_back(rotate(m_phase, int'(bus.i_i), int'(bus.i_q)));
      m_stb = 0;
      if (int'(bus.i_code_rate) != m_rate) begin
        m_phase = 0; m_off = 0; m_sweep = 0;
      end else begin
        if (bus.i_is_sync && !m_sync) m_sweep = 0;
        if (!bus.i_is_sync) begin
          if (bus.i_deperf_next_st) begin
            m_phase = 0;
            m_off = (m_off + 1) % period_of(m_rate);
            if (m_off == 0 && m_sweep < SMAX) m_sweep++;
          end else if (bus.i_next_phase) begin
            if (m_phase == LAST) m_err = 1;
            else begin
              m_phase++;
              m_stb = (m_phase == LAST);
            end
          end
        end
      end
      m_rate = int'(bus.i_code_rate);
      m_sync = bus.i_is_sync;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    samp_t s;
    if (started) begin
      check("o_vld", bus.o_vld, m_vld);
      if (bus.o_vld) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got o_vld=1, expected no pending sample (t=%0t)", $time);
        end else begin
          s = sb.pop_front();
          check("o_i", $signed(bus.o_i), s.i);
          check("o_q", $signed(bus.o_q), s.q);
          m_last_i = s.i;
          m_last_q = s.q;
        end
      end else begin
        check("o_i_hold", $signed(bus.o_i), m_last_i);
        check("o_q_hold", $signed(bus.o_q), m_last_q);
      end
      check("o_phase", bus.o_phase, m_phase);
      check("o_punct_offset", bus.o_punct_offset, m_off);
      check("o_sweep_cnt", bus.o_sweep_cnt, m_sweep);
      check("o_proto_err", bus.o_proto_err, m_err);
      check("o_last_phase_stb", bus.o_last_phase_stb, m_stb);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick_np();
    bus.i_next_phase = 1'b1; tick(); bus.i_next_phase = 1'b0;
  endtask

  task automatic kick_dp();
    bus.i_deperf_next_st = 1'b1; tick(); bus.i_deperf_next_st = 1'b0;
  endtask

  task automatic send(input int i, input int q);
    bus.i_vld = 1'b1; bus.i_i = LW'(i); bus.i_q = LW'(q);
    tick();
    bus.i_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_code_rate = 2'd0; bus.i_next_phase = 1'b0; bus.i_deperf_next_st = 1'b0;
    bus.i_is_sync = 1'b0; bus.i_vld = 1'b0; bus.i_i = '0; bus.i_q = '0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    bus.i_code_rate = 2'd2;
    tick(2);
    for (int p = 0; p < 4; p++) begin
      send(3, -8);
      tick(2);
      if (p < 3) begin
        kick_np();
        tick(9);
      end
    end
    kick_np();
    tick(2);
    repeat (3) begin
      kick_dp();
      tick(3);
    end
    kick_np();
    tick(2);
    bus.i_next_phase = 1'b1; bus.i_deperf_next_st = 1'b1;
    tick();
    bus.i_next_phase = 1'b0; bus.i_deperf_next_st = 1'b0;
    tick(2);
    bus.i_code_rate = 2'd3; bus.i_next_phase = 1'b1;
    tick();
    bus.i_next_phase = 1'b0;
    tick(2);
    bus.i_code_rate = 2'd0;
    tick(2);
    repeat (5) begin
      kick_dp();
      tick();
    end
    bus.i_is_sync = 1'b1; bus.i_next_phase = 1'b1;
    tick();
    bus.i_next_phase = 1'b0;
    tick(3);
    bus.i_is_sync = 1'b0;
    tick(2);
    repeat (SMAX + 5) kick_dp();
    tick(2);
    for (int c = 0; c < 3000; c++) begin
      reset_n              = ($urandom_range(0, 299) != 0);
      bus.i_vld            = $urandom_range(0, 1) == 1;
      bus.i_i              = LW'($urandom_range(0, 15));
      bus.i_q              = LW'($urandom_range(0, 15));
      bus.i_next_phase     = ($urandom_range(0, 4) == 0);
      bus.i_deperf_next_st = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) bus.i_is_sync = ~bus.i_is_sync;
      if ($urandom_range(0, 99) == 0) bus.i_code_rate = 2'($urandom_range(0, 3));
      tick();
    end
    reset_n = 1'b1;
    bus.i_vld = 1'b0; bus.i_next_phase = 1'b0; bus.i_deperf_next_st = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
